ntt_pointwise_seq: RTL and testbench

//   Sequencer for NTT-domain pointwise multiplication, C[i] = A[i]*B[i] mod Q.

---
 rtl/ntt_pointwise_seq.sv | 134 +++++++++++++
 tb/tb_ntt_pointwise_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ntt_pointwise_seq.sv
// Pointwise NTT-domain multiply sequencer: streams A/B coefficients through one
// shared modular multiplier and writes C[i] = A[i]*B[i] mod Q to a result RAM.

module mod_mult #(
  parameter int WIDTH = 32,
  parameter int Q     = 3329
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] r_o
);
  localparam int PW = 2 * WIDTH;

  function automatic logic [WIDTH-1:0] mod_reduce(input logic [PW-1:0] x);
    return WIDTH'(x % PW'(Q));
  endfunction

  logic [PW-1:0] prod;

  assign prod = PW'(a_i) * PW'(b_i);
  assign r_o  = mod_reduce(prod);
endmodule

module ntt_pointwise_seq #(
  parameter int N     = 256,
  parameter int WIDTH = 32,
  parameter int Q     = 3329
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stall,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [$clog2(N)-1:0]     rd_addr,
  input  logic [WIDTH-1:0]         rd_data_a,
  input  logic [WIDTH-1:0]         rd_data_b,
  output logic                     wr_en,
  output logic [$clog2(N)-1:0]     wr_addr,
  output logic [WIDTH-1:0]         wr_data
);
  localparam int                  ADDR_W = $clog2(N);
  localparam logic [ADDR_W-1:0]   LAST   = ADDR_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                issue;
  logic [WIDTH-1:0]    prod_p1;

  logic                vld_p1_q;
  logic [ADDR_W-1:0]   addr_p1_q;
  logic                vld_p2_q;
  logic [ADDR_W-1:0]   addr_p2_q;
  logic [WIDTH-1:0]    data_p2_q;

  assign issue = (state_q == S_RUN) && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Terminal compare on LAST rather than counter wrap so N need not be a power of 2.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (issue) begin
          if (cnt_q == LAST) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (vld_p2_q && (addr_p2_q == LAST)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  mod_mult #(.WIDTH(WIDTH), .Q(Q)) u_mod_mult (
    .a_i (rd_data_a),
    .b_i (rd_data_b),
    .r_o (prod_p1)
  );

  // p1: RAM data returns, product reduced; p2: registered result drives the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      addr_p2_q <= '0;
      data_p2_q <= '0;
    end else begin
      vld_p1_q <= issue;
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        addr_p2_q <= addr_p1_q;
        data_p2_q <= prod_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    addr_p1_q <= cnt_q;
  end

  assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);
  assign rd_en   = issue;
  assign rd_addr = cnt_q;
  assign wr_en   = vld_p2_q;
  assign wr_addr = addr_p2_q;
  assign wr_data = data_p2_q;
endmodule

// File: tb/tb_ntt_pointwise_seq.sv
// Bench for ntt_pointwise_seq: per-run cycle schedule derived from the stall
// pattern and C[i] = A[i]*B[i] mod Q, compared against the DUT every cycle.

module tb_ntt_pointwise_seq;
  localparam int N     = 4;
  localparam int WIDTH = 32;
  localparam int Q     = 3329;
  localparam int AW    = $clog2(N);
  localparam int MAXC  = 64;

  logic             clk = 1'b0;
  logic             rst, start, stall;
  logic             busy, done, rd_en, wr_en;
  logic [AW-1:0]    rd_addr, wr_addr;
  logic [WIDTH-1:0] rd_data_a, rd_data_b, wr_data;

  logic [WIDTH-1:0] mem_a [N];
  logic [WIDTH-1:0] mem_b [N];

  bit     e_rd   [MAXC];
  int     e_ra   [MAXC];
  bit     e_wr   [MAXC];
  int     e_wa   [MAXC];
  longint e_wd   [MAXC];
  bit     e_busy [MAXC];
  bit     e_done [MAXC];
  bit     stl    [MAXC];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ntt_pointwise_seq #(.N(N), .WIDTH(WIDTH), .Q(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  // Coefficient RAMs with one cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr];
      rd_data_b <= mem_b[rd_addr];
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // mode 0: random data, 1: A={1,2,3,4} B={5,6,7,8}, 2: modulus corner values
  task automatic load_mem(input int mode);
    for (int i = 0; i < N; i++) begin
      mem_a[i] = WIDTH'($urandom_range(Q - 1));
      mem_b[i] = WIDTH'($urandom_range(Q - 1));
      if (mode == 1) begin
        mem_a[i] = WIDTH'(i + 1);
        mem_b[i] = WIDTH'(i + 5);
      end
    end
    if (mode == 2) begin
      mem_a[0] = WIDTH'(Q - 1); mem_b[0] = WIDTH'(Q - 1);
      mem_a[1] = WIDTH'(2000);  mem_b[1] = WIDTH'(2);
    end
  endtask

  task automatic do_run(input int mode, input int stall_pct, input logic [MAXC-1:0] smask,
                        input bit hold, input int rst_at);
    int rdc [N];
    int issued, last, len, w;
    load_mem(mode);
    for (int k = 0; k < MAXC; k++) begin
      e_rd[k] = 0; e_ra[k] = 0; e_wr[k] = 0; e_wa[k] = 0; e_wd[k] = 0;
      e_busy[k] = 0; e_done[k] = 0;
      stl[k] = (k < MAXC / 2) &&
               (smask[k] || (int'($urandom_range(99)) < stall_pct));
    end
    issued = 0;
    for (int k = 1; issued < N; k++) begin
      if (!stl[k]) begin
        e_rd[k] = 1; e_ra[k] = issued; rdc[issued] = k; issued++;
      end
    end
    for (int i = 0; i < N; i++) begin
      w = rdc[i] + 2;
      e_wr[w] = 1; e_wa[w] = i;
      e_wd[w] = (longint'(mem_a[i]) * longint'(mem_b[i])) % longint'(Q);
    end
    last = rdc[N-1] + 2;
    for (int k = 1; k <= last; k++) e_busy[k] = 1;
    e_done[last+1] = 1;
    len = (rst_at >= 0) ? rst_at + 1 : last + 1;
    for (int k = 0; k <= len; k++) begin
      @(posedge clk); #1;
      rst   = (k == rst_at);
      start = (rst_at >= 0 && k > rst_at) ? 1'b0 : (hold || k == 0);
      stall = stl[k];
      @(negedge clk);
      if (rst_at >= 0 && k > rst_at) begin
        chk("rst_rd_en", longint'(rd_en), 0);
        chk("rst_rd_addr", longint'(rd_addr), 0);
        chk("rst_wr_en", longint'(wr_en), 0);
        chk("rst_wr_addr", longint'(wr_addr), 0);
        chk("rst_wr_data", longint'(wr_data), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
      end else begin
        chk("rd_en", longint'(rd_en), longint'(e_rd[k]));
        if (e_rd[k]) chk("rd_addr", longint'(rd_addr), longint'(e_ra[k]));
        chk("wr_en", longint'(wr_en), longint'(e_wr[k]));
        if (e_wr[k]) begin
          chk("wr_addr", longint'(wr_addr), longint'(e_wa[k]));
          chk("wr_data", longint'(wr_data), e_wd[k]);
        end
        chk("busy", longint'(busy), longint'(e_busy[k]));
        chk("done", longint'(done), longint'(e_done[k]));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_rd_en", longint'(rd_en), 0);
    chk("reset_rd_addr", longint'(rd_addr), 0);
    chk("reset_wr_en", longint'(wr_en), 0);
    chk("reset_wr_addr", longint'(wr_addr), 0);
    chk("reset_wr_data", longint'(wr_data), 0);
    rst = 1'b0;
    @(posedge clk);

    do_run(1, 0, '0, 1'b0, -1);                   // plain run, known products
    do_run(2, 0, '0, 1'b0, -1);                   // (Q-1)^2 and 2000*2 wrap
    do_run(1, 0, MAXC'(64'b1100), 1'b0, -1);      // stall during cycles 2..3
    do_run(0, 0, '0, 1'b1, -1);                   // start held through the run
    do_run(0, 0, '0, 1'b0, -1);                   // back-to-back from held start
    do_run(1, 0, '0, 1'b0, 4);                    // reset with writes in flight
    do_run(1, 0, '0, 1'b0, -1);                   // clean run after reset
    for (int r = 0; r < 24; r++)
      do_run(0, (r % 3) * 25, '0, r[0], (r % 7 == 6) ? int'($urandom_range(6, 1)) : -1);
    do_run(0, 40, '0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
